mul_div_seq: RTL and testbench
==============================

// Module: mul_div_seq
// PURPOSE
//  Parametrised, iterative RISC-V M-extension unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
//  One result bit per cycle for both multiply (shift-add) and divide (restoring).
//  Sits in the EX stage behind a valid/ready handshake so the pipeline stalls on busy.
//  Successor of the single-op combinational mul/div wrapper: adds divide, width and handshake.
// PARAMETERS
//  XLEN       32  operand/result width (>=8, even)
//  FAST_SPEC  1   1: div-by-zero and signed overflow bypass iteration (1-cycle result)
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     reset, asynchronous, active-high
//  valid_i    in   1     request valid
//  ready_o    out  1     unit can accept a request (high only in IDLE)
//  op_i       in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  a_i        in   XLEN  rs1 operand
//  b_i        in   XLEN  rs2 operand
//  flush_i    in   1     abort in-flight op (pipeline kill)
//  valid_o    out  1     result valid
//  ready_i    in   1     consumer accepts result
//  res_o      out  XLEN  result; held stable while valid_o && !ready_i
// BEHAVIOUR
//  Reset (rst=1, any time): state=IDLE, ready_o=1, valid_o=0, res_o=0, counter=0.
//  Accept: valid_i && ready_o on a rising edge; a_i,b_i,op_i latched; inputs ignored otherwise.
//  FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   IDLE: ready_o=1. On accept: special case & FAST_SPEC -> DONE, else -> CALC, counter=XLEN-1.
//   CALC: XLEN iterations on |operands| (signedness per op); counter decrements; at 0 -> FIX.
//   FIX : apply sign correction, select low/high product or quotient/remainder -> DONE.
//   DONE: valid_o=1, res_o registered; on ready_i -> IDLE (valid_o low next cycle).
//  Latency (accept edge to valid_o high): normal XLEN+2 cycles; special case 1 cycle.
//  No back-to-back: ready_o=0 in CALC/FIX/DONE; next accept earliest cycle after DONE handshake.
//  Signedness: MULH/DIV/REM both signed; MULHSU a signed, b unsigned; others unsigned.
//  Multiply: full 2*XLEN product; MUL returns [XLEN-1:0], MULH* return [2*XLEN-1:XLEN].
//   Product negated in FIX iff sign(a)^sign(b) for the signed-treated operands.
//  Divide: quotient negated iff sign(a)^sign(b) (signed ops); remainder takes sign of a.
//  Special cases (RISC-V spec):
//   b=0: DIV/DIVU -> all ones; REM/REMU -> a.
//   DIV a=MIN_INT, b=-1 -> MIN_INT; REM same operands -> 0.
//   FAST_SPEC=0: special cases iterate, FIX forces the same values; latency XLEN+2.
//  Multiply by 0 iterates normally (no early out).
//  flush_i: in CALC/FIX -> IDLE next edge, valid_o never asserted for that op.
//   flush_i in DONE -> IDLE, valid_o low next cycle. flush_i in IDLE ignored;
//   flush_i && valid_i same edge in IDLE: request not accepted.
//  valid_o && ready_i && flush_i same edge: treated as handshake (result consumed).
//  res_o only changes on entry to DONE or on reset.
// TESTING
//  MUL a=7,b=-3 (0xFFFFFFFD), ready_i=1 -> res_o=0xFFFFFFEB, valid_o 34 cycles after accept.
//  MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same -> 0; MULHSU a=-1,b=0xFFFFFFFF -> 0xFFFFFFFF.
//  DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 0x80000000/3 -> 0x2AAAAAAA.
//  DIV by 0 -> 0xFFFFFFFF in 1 cycle; REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
//  Hold result with ready_i=0 for 10 cycles -> res_o/valid_o stable, ready_o=0, valid_i ignored.
//  flush_i mid-CALC then new MUL 3*4 -> no stale valid_o, res_o=12; rst mid-CALC -> all outputs reset.

Source files
------------

// File: rtl/mul_div_seq_if.sv
// Request/response bundle for the iterative mul/div unit.
// The slave side is the unit; the master side is the EX stage that issues ops and takes results.
interface mul_div_seq_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_op;
  logic [XLEN-1:0] i_a;
  logic [XLEN-1:0] i_b;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_res;

  modport slave (
    input  i_valid, i_op, i_a, i_b, i_flush, i_ready,
    output o_ready, o_valid, o_res
  );

  modport master (
    output i_valid, i_op, i_a, i_b, i_flush, i_ready,
    input  o_ready, o_valid, o_res
  );
endinterface

// File: rtl/mul_div_seq.sv
// Iterative RISC-V M-extension unit: shift-add multiply / restoring divide, one bit per cycle,
// operating on magnitudes with sign fix-up at the end.
module mul_div_seq #(
  parameter int XLEN      = 32,
  parameter bit FAST_SPEC = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  mul_div_seq_if.slave  bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic spec_hit(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    return op[2] && ((b == '0) || (!op[0] && (a == MIN_INT) && (b == '1)));
  endfunction

  function automatic logic [XLEN-1:0] spec_val(input logic [2:0] op, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    if (b == '0) return op[1] ? a : '1;
    return op[1] ? '0 : MIN_INT;
  endfunction

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_a, r_b;
  logic [XLEN-1:0] r_hi, r_lo, r_opd;
  logic            r_neg_a, r_neg_b;
  logic [XLEN-1:0] r_res;

  // Request decode on the live inputs (only meaningful on the accept edge).
  logic            w_accept, w_is_div, w_sa, w_sb, w_neg_a, w_neg_b, w_hit;
  logic [XLEN-1:0] w_abs_a, w_abs_b;

  assign w_accept = bus.i_valid && !bus.i_flush && (r_state == S_IDLE);
  assign w_is_div = bus.i_op[2];
  assign w_sa     = (bus.i_op == 3'd1) || (bus.i_op == 3'd2) || (bus.i_op[2] && !bus.i_op[0]);
  assign w_sb     = (bus.i_op == 3'd1) || (bus.i_op[2] && !bus.i_op[0]);
  assign w_neg_a  = w_sa && bus.i_a[XLEN-1];
  assign w_neg_b  = w_sb && bus.i_b[XLEN-1];
  assign w_abs_a  = w_neg_a ? -bus.i_a : bus.i_a;
  assign w_abs_b  = w_neg_b ? -bus.i_b : bus.i_b;
  assign w_hit    = spec_hit(bus.i_op, bus.i_a, bus.i_b);

  // Multiply step: r_lo holds the multiplier, consumed LSB first while product bits shift in.
  logic [XLEN:0]   w_msum;
  assign w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);

  // Divide step: r_hi is the partial remainder, r_lo shifts dividend out / quotient in.
  logic [XLEN:0]   w_dshift;
  logic [XLEN+1:0] w_ddiff;
  logic            w_dge;
  assign w_dshift = {r_hi, r_lo[XLEN-1]};
  assign w_ddiff  = {1'b0, w_dshift} - {2'b00, r_opd};
  assign w_dge    = !w_ddiff[XLEN+1];

  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0]   w_quo, w_rem, w_fix;
  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
  assign w_quo    = (r_neg_a ^ r_neg_b) ? -r_lo : r_lo;
  assign w_rem    = r_neg_a ? -r_hi : r_hi;

  always_comb begin
    w_fix = '0;
    if (spec_hit(r_op, r_a, r_b))  w_fix = spec_val(r_op, r_a, r_b);
    else if (!r_op[2])             w_fix = (r_op == 3'd0) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
    else                           w_fix = r_op[1] ? w_rem : w_quo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_opd   <= '0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_res   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op    <= bus.i_op;
          r_a     <= bus.i_a;
          r_b     <= bus.i_b;
          r_neg_a <= w_neg_a;
          r_neg_b <= w_neg_b;
          r_hi    <= '0;
          r_lo    <= w_is_div ? w_abs_a : w_abs_b;
          r_opd   <= w_is_div ? w_abs_b : w_abs_a;
          if (FAST_SPEC && w_hit) begin
            r_res   <= spec_val(bus.i_op, bus.i_a, bus.i_b);
            r_state <= S_DONE;
          end else begin
            r_cnt   <= CW'(XLEN-1);
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          if (bus.i_flush) begin
            r_state <= S_IDLE;
          end else begin
            if (r_op[2]) begin
              r_hi <= w_dge ? w_ddiff[XLEN-1:0] : w_dshift[XLEN-1:0];
              r_lo <= {r_lo[XLEN-2:0], w_dge};
            end else begin
              r_hi <= w_msum[XLEN:1];
              r_lo <= {w_msum[0], r_lo[XLEN-1:1]};
            end
            if (r_cnt == '0) r_state <= S_FIX;
            else             r_cnt   <= r_cnt - 1'b1;
          end
        end
        S_FIX: begin
          if (bus.i_flush) begin
            r_state <= S_IDLE;
          end else begin
            r_res   <= w_fix;
            r_state <= S_DONE;
          end
        end
        default: if (bus.i_ready || bus.i_flush) r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ready = (r_state == S_IDLE);
  assign bus.o_valid = (r_state == S_DONE);
  assign bus.o_res   = r_res;
endmodule

// File: tb/tb_mul_div_seq.sv
// Directed bench for mul_div_seq: vector table for results/latency, hand sequences for
// result hold, flush in CALC/DONE/IDLE and reset mid-operation.
module tb_mul_div_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  mul_div_seq_if #(.XLEN(32)) bus();
  mul_div_seq #(.XLEN(32), .FAST_SPEC(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; waits for ready, issues one request, returns at the negedge after accept.
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    while (!bus.o_ready && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) chk("ready_timeout", {63'd0, bus.o_ready}, 64'd1);
    bus.i_op = op; bus.i_a = a; bus.i_b = b; bus.i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  // lat counts edges from accept: 1 means valid_o is up right after the accept edge.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.o_valid && lat < 200) begin @(negedge clk); lat++; end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    launch(op, a, b);
    wait_valid(lat);
    res = bus.o_res;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] res;
    int          lat;

    vecs.push_back('{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul_7_m3"});
    vecs.push_back('{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu_max"});
    vecs.push_back('{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34, "mulh_m1_m1"});
    vecs.push_back('{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, "mulhsu_m1_max"});
    vecs.push_back('{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34, "mulh_min_min"});
    vecs.push_back('{3'd2, 32'd2,        32'h80000000, 32'h00000001, 34, "mulhsu_2_big"});
    vecs.push_back('{3'd0, 32'd0,        32'h12345678, 32'h00000000, 34, "mul_zero"});
    vecs.push_back('{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, "div_m7_2"});
    vecs.push_back('{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, "rem_m7_2"});
    vecs.push_back('{3'd6, 32'd7,        32'hFFFFFFFE, 32'h00000001, 34, "rem_7_m2"});
    vecs.push_back('{3'd5, 32'h80000000, 32'd3,        32'h2AAAAAAA, 34, "divu_min_3"});
    vecs.push_back('{3'd5, 32'd100,      32'd7,        32'h0000000E, 34, "divu_100_7"});
    vecs.push_back('{3'd7, 32'd100,      32'd7,        32'h00000002, 34, "remu_100_7"});
    vecs.push_back('{3'd4, 32'd1234,     32'd0,        32'hFFFFFFFF,  1, "div_by0"});
    vecs.push_back('{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF,  1, "divu_by0"});
    vecs.push_back('{3'd7, 32'd5,        32'd0,        32'h00000005,  1, "remu_by0"});
    vecs.push_back('{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,  1, "div_ovf"});
    vecs.push_back('{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000,  1, "rem_ovf"});

    bus.i_valid = 1'b0; bus.i_op = '0; bus.i_a = '0; bus.i_b = '0;
    bus.i_flush = 1'b0; bus.i_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_state", {bus.o_valid, bus.o_ready, bus.o_res}, {1'b0, 1'b1, 32'd0});
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      chk({vecs[i].name, "_res"}, {32'd0, res}, {32'd0, vecs[i].exp});
      chk({vecs[i].name, "_lat"}, lat, vecs[i].lat);
    end

    // Result hold with consumer stalled; new requests must be ignored.
    bus.i_ready = 1'b0;
    launch(3'd5, 32'd100, 32'd7);
    wait_valid(lat);
    chk("hold_lat", lat, 34);
    bus.i_valid = 1'b1; bus.i_op = 3'd0; bus.i_a = 32'd1; bus.i_b = 32'd1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("hold_stable", {bus.o_valid, bus.o_ready, bus.o_res}, {1'b1, 1'b0, 32'd14});
    end
    bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    @(negedge clk);
    chk("hold_release", {bus.o_valid, bus.o_ready, bus.o_res}, {1'b0, 1'b1, 32'd14});

    // Flush in DONE drops the result without a handshake.
    bus.i_ready = 1'b0;
    launch(3'd7, 32'd100, 32'd7);
    wait_valid(lat);
    chk("flush_done_res", {32'd0, bus.o_res}, 64'd2);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0; bus.i_ready = 1'b1;
    chk("flush_done_idle", {bus.o_valid, bus.o_ready, bus.o_res}, {1'b0, 1'b1, 32'd2});

    // Flush mid-CALC: no result, res_o keeps the last value.
    launch(3'd0, 32'd5, 32'd6);
    repeat (10) @(negedge clk);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    chk("flush_calc_idle", {bus.o_valid, bus.o_ready, bus.o_res}, {1'b0, 1'b1, 32'd2});

    // Flush together with valid in IDLE: request not taken.
    bus.i_valid = 1'b1; bus.i_flush = 1'b1; bus.i_op = 3'd0; bus.i_a = 32'd9; bus.i_b = 32'd9;
    @(negedge clk);
    bus.i_valid = 1'b0; bus.i_flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_noaccept", {bus.o_valid, bus.o_ready}, {1'b0, 1'b1});

    run_op(3'd0, 32'd3, 32'd4, res, lat);
    chk("after_flush_res", {32'd0, res}, 64'd12);
    chk("after_flush_lat", lat, 34);

    // Asynchronous reset mid-CALC.
    launch(3'd4, 32'd100, 32'd3);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_calc", {bus.o_valid, bus.o_ready, bus.o_res}, {1'b0, 1'b1, 32'd0});
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stays_idle", {bus.o_valid, bus.o_ready, bus.o_res}, {1'b0, 1'b1, 32'd0});

    run_op(3'd4, 32'd100, 32'd3, res, lat);
    chk("after_rst_div", {32'd0, res}, 64'd33);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
